// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with NUM_RD combinational read ports, a per-register
// busy scoreboard and a sequential clear sweep. Optional forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DEPTH-1:0]    busy_q, busy_d;

    // Storage has no reset so it can map onto distributed RAM; the sweep clears it instead.
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WIDTH-1:0]    mem_wdata;

    logic                run;
    logic                wr_hit;
    logic                rsv_hit;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_X);
    endfunction

    assign run     = (state_q == ST_RUN);
    assign ready   = run;
    assign wr_hit  = run && wr_en && addr_ok(wr_addr);
    assign rsv_hit = run && rsv_en && addr_ok(rsv_addr);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_hit) begin
                    mem_we          = 1'b1;
                    busy_d[wr_addr] = 1'b0;
                end
                // Reservation is applied after the release so a new producer wins.
                if (rsv_hit) begin
                    busy_d[rsv_addr] = 1'b1;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ra_ok;
        logic [WIDTH-1:0]  data_i;
        logic              busy_i;

        assign ra    = rd_addr[i*ADDR_W +: ADDR_W];
        assign ra_ok = run && addr_ok(ra);

        always_comb begin
            data_i = '0;
            busy_i = 1'b0;
            if (ra_ok) begin
                data_i = mem[ra];
                busy_i = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_addr == ra)) begin
                    data_i = wr_data;
                    busy_i = 1'b0;
                end
`endif
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = data_i;
        assign rd_busy[i]                = busy_i;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default instance (DEPTH=32, NUM_RD=2)
// and a DEPTH=24, NUM_RD=4 instance sharing clock and reset.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ready;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic         p_ready;
    logic [19:0]  p_rd_addr;
    logic [127:0] p_rd_data;
    logic [3:0]   p_rd_busy;
    logic         p_wr_en;
    logic [4:0]   p_wr_addr;
    logic [31:0]  p_wr_data;
    logic         p_rsv_en;
    logic [4:0]   p_rsv_addr;

    int n_compared   = 0;
    int n_mismatched = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    regfile_scoreboard #(.WIDTH(32), .DEPTH(24), .NUM_RD(4)) dut_p (
        .clk(clk), .rst(rst), .ready(p_ready),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t vecs[12];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive the default instance at posedge+1, then settle to posedge+2.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [4:0] ra,
                                 input logic [4:0] r0, input logic [4:0] r1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        rd_addr  = {r1, r0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRead(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic b0, input logic b1);
        checkOutput({name, " data0"}, rd_data[31:0], e0);
        checkOutput({name, " data1"}, rd_data[63:32], e1);
        checkOutput({name, " busy0"}, 32'(rd_busy[0]), 32'(b0));
        checkOutput({name, " busy1"}, 32'(rd_busy[1]), 32'(b1));
    endtask

    task automatic waitReady(input int exp_cycles, input string name);
        int   n;
        int   p_at;
        logic leak;
        n    = 0;
        p_at = 0;
        leak = 1'b0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (p_ready && p_at == 0) p_at = n;
            if (!ready && (rd_data != '0 || rd_busy != '0)) leak = 1'b1;
        end
        checkOutput({name, " ready cycles"}, 32'(n), 32'(exp_cycles));
        checkOutput({name, " p ready cycles"}, 32'(p_at), 32'd24);
        checkOutput({name, " init quiet"}, 32'(leak), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd8, 32'hCAFEF00D, 1'b0, 5'd0, 5'd7, 5'd1, 32'h12345678, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 5'd8, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd0, 5'd8, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd3, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h12345678, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd3, 32'hAA,       1'b1, 5'd3, 5'd7, 5'd8, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'hAA,       32'hAA,       1'b1, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd8, 32'hAA,       32'hCAFEF00D, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd3, 32'h77,       1'b0, 5'd0, 5'd8, 5'd7, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h77,       32'h77,       1'b0, 1'b0};

        p_wr_en = 1'b0; p_wr_addr = '0; p_wr_data = '0;
        p_rsv_en = 1'b0; p_rsv_addr = '0; p_rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;

        $display("[TB] reset and init sweep");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", 32'(ready), 32'd0);
        rst = 1'b0;
        // Writes and reservations during the sweep must be dropped.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd6; rd_addr = {5'd6, 5'd5};
        waitReady(32, "init");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        checkRead("post-init x5/x6", 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd1);
        checkRead("post-init x31/x1", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].r0, vecs[i].r1);
            checkRead($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].b0, vecs[i].b1);
            tick();
        end

        $display("[TB] write/read forwarding");
        applyStimulus(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 5'd9, 5'd9);
        if (BYP) checkRead("bypass same-cycle", 32'hABCD, 32'hABCD, 1'b0, 1'b0);
        else     checkRead("bypass same-cycle", 32'h1, 32'h1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 5'd9, 5'd9);
        if (BYP) checkRead("bypass wr+rsv", 32'h2, 32'h2, 1'b0, 1'b0);
        else     checkRead("bypass wr+rsv", 32'hABCD, 32'hABCD, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        checkRead("bypass after", 32'h2, 32'h2, 1'b1, 1'b1);
        tick();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        checkRead("x4 busy before rst", 32'h44, 32'h44, 1'b1, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async rst ready", 32'(ready), 32'd0);
        checkOutput("async rst busy", 32'(rd_busy), 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid-sweep rst ready", 32'(ready), 32'd0);
        tick();
        rst = 1'b0;
        waitReady(32, "resweep");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
        checkRead("x4/x9 after resweep", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("[TB] DEPTH=24 NUM_RD=4 instance");
        p_wr_en = 1'b1; p_wr_addr = 5'd1; p_wr_data = 32'h11;
        tick();
        p_wr_addr = 5'd2; p_wr_data = 32'h22;
        tick();
        p_wr_addr = 5'd23; p_wr_data = 32'h2323; p_rsv_en = 1'b1; p_rsv_addr = 5'd30;
        tick();
        p_wr_addr = 5'd30; p_wr_data = 32'h3030; p_rsv_addr = 5'd5;
        tick();
        p_wr_en = 1'b0; p_rsv_en = 1'b0;
        p_rd_addr = {5'd30, 5'd23, 5'd2, 5'd1};
        #1;
        checkOutput("p port0 x1", p_rd_data[31:0], 32'h11);
        checkOutput("p port1 x2", p_rd_data[63:32], 32'h22);
        checkOutput("p port2 x23", p_rd_data[95:64], 32'h2323);
        checkOutput("p port3 x30", p_rd_data[127:96], 32'h0);
        checkOutput("p busy x1/x2/x23/x30", 32'(p_rd_busy), 32'h0);
        p_rd_addr = {5'd23, 5'd30, 5'd5, 5'd1};
        #1;
        checkOutput("p busy x1/x5/x30/x23", 32'(p_rd_busy), 32'b0010);
        checkOutput("p port1 x5", p_rd_data[63:32], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
